// File: rtl/proc_op_sequencer.sv
// Op sequencer: buffers 4-bit processor ops in a small FIFO and issues them one at a
// time to a regfile + clocked ALU datapath, returning captured results over valid/ready.
module proc_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_opcode,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [2:0] p_opcode,
    output logic [3:0] p_inp1,
    output logic [3:0] p_inp2,
    output logic       p_reg_w_enable,
    input  logic [3:0] p_result,
    input  logic       p_SF,
    input  logic       p_ZF,
    input  logic       p_CF,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result,
    output logic [2:0] out_flags,
    output logic       out_error,
    output logic [7:0] ops_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [2:0] OP_WRITE = 3'b100;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } op_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, state_next;
    op_t            mem [DEPTH];
    op_t            head, cur;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [CW-1:0]  lat_cnt;
    logic           full, empty, push, pop, head_ok, lat_last;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    // A pop in the same cycle never frees space for a push while full.
    assign push     = in_valid && !full;
    assign pop      = (state == IDLE) && !empty;
    assign head     = mem[rd_ptr];
    assign head_ok  = (head.op <= OP_WRITE);
    assign lat_last = (lat_cnt == CW'(LATENCY - 1));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{op: in_opcode, a: in_a, b: in_b};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next     = state;
        p_opcode       = 3'b000;
        p_inp1         = 4'd0;
        p_inp2         = 4'd0;
        p_reg_w_enable = 1'b0;
        out_valid      = 1'b0;
        case (state)
            IDLE: if (!empty) state_next = head_ok ? ISSUE : RESP;
            ISSUE: begin
                p_opcode       = cur.op;
                p_inp1         = cur.a;
                p_inp2         = cur.b;
                p_reg_w_enable = (cur.op == OP_WRITE);
                state_next     = WAIT;
            end
            WAIT: begin
                p_opcode = cur.op;
                p_inp1   = cur.a;
                p_inp2   = cur.b;
                if (lat_last) state_next = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= '0;
            lat_cnt    <= '0;
            out_result <= 4'd0;
            out_flags  <= 3'b000;
            out_error  <= 1'b0;
            ops_done   <= 8'd0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    cur        <= head;
                    lat_cnt    <= '0;
                    out_result <= 4'd0;
                    out_flags  <= 3'b000;
                    out_error  <= !head_ok;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    // Writes return zero; only ALU ops report datapath output.
                    if (lat_last && cur.op != OP_WRITE) begin
                        out_result <= p_result;
                        out_flags  <= {p_SF, p_ZF, p_CF};
                    end
                end
                RESP: if (out_ready) ops_done <= ops_done + 8'd1;
                default: ;
            endcase
        end
    end
endmodule
